muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine implementing the RV32M/RV64M operations for the multi-cycle RISC-V core.
- Sits beside the ALU in the multi-cycle datapath.
- The controller holds its FSM in a wait state while busy=1, then writes result through the result mux on done.
- Adds variable-latency, handshaked execution that the single-cycle ALU path does not have.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- start  input  1  request; sampled only in IDLE.
- func3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  XLEN  rs1 operand (multiplicand/dividend).
- src_b  input  XLEN  rs2 operand (multiplier/divisor).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result valid in that cycle.
- result  output  XLEN  registered result; holds until the next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared.
- Reset mid-operation aborts the operation; no done pulse is generated.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 at edge k latches func3 and operand magnitudes, plus the result-sign and remainder-sign flags.
  - Fast-path cases go to FIN; all others go to CALC with counter=0.
  - start while busy=1 or in FIN is ignored.
- Signedness:
  - src_a is signed for MULH, MULHSU, DIV, REM.
  - src_b is signed for MULH, DIV, REM.
  - Negative signed operands are converted to two's-complement magnitude (XLEN+1-bit safe, so the most-negative value works).
- CALC (exactly XLEN cycles):
  - Multiply: shift-add over a 2*XLEN accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first; partial remainder is XLEN+1 bits.
  - The counter increments each cycle; at counter=XLEN-1 the next state is FIN.
- FIN (one cycle):
  - Apply sign: product negated at 2*XLEN if the sign flag is set.
  - Quotient is negated if operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
  - Select output: MUL = product[XLEN-1:0]; MULH* = product[2XLEN-1:XLEN]; DIV* = quotient; REM* = remainder.
  - result registered, done=1, busy=0 at the next edge; then return to IDLE.
- Latency, with start accepted at edge k:
  - Normal ops: done=1 and result valid during cycle k+XLEN+1; busy=1 for cycles k+1..k+XLEN.
  - Fast path: done during cycle k+1; busy never asserts.
- Fast path, resolved in IDLE:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → src_a.
  - Signed overflow (src_a = -2^(XLEN-1), src_b = -1): DIV → src_a; REM → 0.
  - No exception or flag is raised.
- A new start is accepted in the IDLE cycle after done, so back-to-back throughput is XLEN+2 cycles per op.
- Operand inputs may change after acceptance without affecting the operation.

Decomposition:
- Package muldiv_pkg holds:
  - func3 localparams (F_MUL .. F_REMU).
  - State encoding (S_IDLE=2'd0, S_CALC=2'd1, S_FIN=2'd2).
  - Helper function is_div(func3) = func3[2].
- Single module. The sign-conversion/negation logic is the natural candidate for one sub-module, muldiv_sign_fix (combinational magnitude/negate helper), instantiated twice: at operand entry and at FIN.

Test Plan:
- Reset, then MUL 7 × 0xFFFFFFFD (−3), XLEN=32:
  - result=0xFFFFFFEB.
  - done exactly 33 cycles after the start edge.
  - busy high for 32 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Fast path, each with done one cycle after start and busy never asserted:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- start pulsed with new operands during busy (cycle k+5) → ignored; the original result is unchanged.
- rst=0 at cycle k+10 → busy=0, done=0, result=0 immediately (async); after release, MUL 3×4 → 12 with normal latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M/RV64M multiply/divide engine.
package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] f);
    return f >= 3'b100;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: yields a magnitude at operand entry
// and re-applies the sign to the final product/quotient/remainder.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a single-cycle fast path for divide corner cases.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              fast_q;
  logic              busy_q;
  logic              done_q;

  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] fast_res;

  assign a_signed = (func3 == F_MULH) || (func3 == F_MULHSU) ||
                    (func3 == F_DIV)  || (func3 == F_REM);
  assign b_signed = (func3 == F_MULH) || (func3 == F_DIV) || (func3 == F_REM);
  assign a_neg    = a_signed && src_a[XLEN-1];
  assign b_neg    = b_signed && src_b[XLEN-1];

  muldiv_sign_fix #(.W(XLEN)) u_fix_a (.val_i(src_a), .neg_i(a_neg), .res_o(a_mag));
  muldiv_sign_fix #(.W(XLEN)) u_fix_b (.val_i(src_b), .neg_i(b_neg), .res_o(b_mag));

  // func3[1] distinguishes REM/REMU from DIV/DIVU
  assign div_zero = is_div(func3) && (src_b == '0);
  assign div_ovf  = ((func3 == F_DIV) || (func3 == F_REM)) &&
                    (src_a == MIN_NEG) && (src_b == '1);
  assign fast_res = div_zero ? (func3[1] ? src_a : '1)
                             : (func3[1] ? '0 : src_a);

  // Multiply step: add into the upper half, then shift the accumulator right.
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_d;

  assign mul_addend = b_q[0] ? a_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign acc_d      = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: dividend shifts out of a_q MSB-first while quotient bits shift in.
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;

  assign div_shift = {rem_q, a_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign rem_d     = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
  assign quo_d     = {a_q[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] fin_raw;
  logic [2*XLEN-1:0] fin_val;
  logic              fin_neg;
  logic [XLEN-1:0]   fin_sel;

  assign fin_raw = !is_div(op_q) ? acc_q : {{XLEN{1'b0}}, (op_q[1] ? rem_q : a_q)};
  assign fin_neg = (is_div(op_q) && op_q[1]) ? neg_rem_q : neg_res_q;

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_out (.val_i(fin_raw), .neg_i(fin_neg), .res_o(fin_val));

  always_comb begin
    fin_sel = fin_val[XLEN-1:0];
    case (op_q)
      F_MULH, F_MULHSU, F_MULHU:          fin_sel = fin_val[2*XLEN-1:XLEN];
      F_MUL, F_DIV, F_DIVU, F_REM, F_REMU: fin_sel = fin_val[XLEN-1:0];
      default:                            fin_sel = fin_val[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      fast_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q      <= func3;
            a_q       <= a_mag;
            b_q       <= b_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (div_zero || div_ovf) begin
              fast_q  <= 1'b1;
              acc_q   <= {{XLEN{1'b0}}, fast_res};
              state_q <= S_FIN;
            end else begin
              fast_q  <= 1'b0;
              acc_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div(op_q)) begin
            a_q   <= quo_d;
            rem_q <= rem_d;
          end else begin
            acc_q <= acc_d;
            b_q   <= b_q >> 1;
          end
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          result_q <= fast_q ? acc_q[XLEN-1:0] : fin_sel;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed corner cases plus
// randomized operations compared cycle-by-cycle against an arithmetic model.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  int          n_ops = 0;

  // Outstanding-operation model shared by stimulus and compare processes.
  bit          act_valid = 1'b0;
  bit          act_fast = 1'b0;
  int          act_k = 0;
  logic [31:0] act_exp = '0;
  logic [31:0] last_res = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f < 3'd4) return 1'b0;
    if (b == 32'h0) return 1'b1;
    return ((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hffff_ffff);
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ubs;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ubs = longint'({32'h0, b});
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    p   = '0;
    case (f)
      3'd0, 3'd3: p = ua * ub;
      3'd1:       p = sa * sb;
      3'd2:       p = sa * ubs;
      default:    p = '0;
    endcase
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 32'h0) return 32'hffff_ffff;
        if (ovf) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 32'h0) return 32'hffff_ffff;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Compare process: every falling edge, busy/done/result against the model.
  initial begin : compare
    bit exp_busy;
    bit exp_done;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_result", 64'(result), 64'(0));
      end else begin
        exp_busy = act_valid && !act_fast && (edge_cnt >= act_k) && (edge_cnt <= act_k + XLEN - 1);
        exp_done = act_valid && (edge_cnt == act_k + (act_fast ? 1 : XLEN + 1));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(exp_done));
        if (exp_done) begin
          chk("result", 64'(result), 64'(act_exp));
          last_res  = act_exp;
          act_valid = 1'b0;
        end else begin
          chk("result_hold", 64'(result), 64'(last_res));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (act_valid && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (act_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: actual=no done after 50 cycles required=done", name);
      act_valid = 1'b0;
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    wait_idle("idle");
    @(negedge clk);
    func3 = f;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    act_k     = edge_cnt;
    act_fast  = ref_fast(f, a, b);
    act_exp   = ref_op(f, a, b);
    act_valid = 1'b1;
    n_ops++;
    $display("op %0d: func3=%0d a=%h b=%h expect=%h fast=%0d start_edge=%0d",
             n_ops, f, a, b, act_exp, act_fast, act_k);
    // operands are free to change once accepted
    src_a = $urandom;
    src_b = $urandom;
    func3 = 3'($urandom_range(0, 7));
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit);
    chk({"model_", name}, 64'(ref_op(f, a, b)), 64'(lit));
    do_op(f, a, b);
    wait_idle(name);
    @(negedge clk);
    chk({"lit_", name}, 64'(result), 64'(lit));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hffff_ffff;
      2:       return 32'h0;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    rst   = 1'b0;
    start = 1'b0;
    func3 = '0;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    directed("mul_7_m3",     3'd0, 32'd7,          32'hffff_fffd, 32'hffff_ffeb);
    directed("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    directed("mulhu_ones",   3'd3, 32'hffff_ffff,  32'hffff_ffff, 32'hffff_fffe);
    directed("mulhsu_ones",  3'd2, 32'hffff_ffff,  32'hffff_ffff, 32'hffff_ffff);
    directed("div_m7_2",     3'd4, 32'hffff_fff9,  32'd2,         32'hffff_fffd);
    directed("rem_m7_2",     3'd6, 32'hffff_fff9,  32'd2,         32'hffff_ffff);
    directed("divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14);
    directed("remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2);
    directed("div_by_zero",  3'd4, 32'd5,          32'd0,         32'hffff_ffff);
    directed("remu_by_zero", 3'd7, 32'd5,          32'd0,         32'd5);
    directed("div_ovf",      3'd4, 32'h8000_0000,  32'hffff_ffff, 32'h8000_0000);
    directed("rem_ovf",      3'd6, 32'h8000_0000,  32'hffff_ffff, 32'h0);

    // start pulsed during busy must be ignored
    do_op(3'd5, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    func3 = 3'd0;
    src_a = 32'd9;
    src_b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("ignored_start");
    @(negedge clk);
    chk("ignored_start_result", 64'(result), 64'(32'd14));

    // asynchronous reset mid-operation
    do_op(3'd0, 32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #2;
    rst       = 1'b0;
    act_valid = 1'b0;
    last_res  = '0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_done", 64'(done), 64'(0));
    chk("async_rst_result", 64'(result), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    directed("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12);

    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
    end
    wait_idle("final");
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
